// File: rtl/deconvolution_stream.sv
// deconvolution_stream: recovers x from y = x*h by recursive long division with a monic kernel
module deconvolution_stream #(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int XW = 8,
  parameter int HW = 8,
  parameter int YW = 16,
  parameter int AW = YW + HW + XW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [M*HW-1:0] h_flat,
  input  logic [YW-1:0] y_data,
  input  logic          y_valid,
  output logic          y_ready,
  output logic [XW-1:0] x_data,
  output logic          x_valid,
  input  logic          x_ready,
  output logic          x_last,
  output logic          busy,
  output logic          done,
  output logic          err_kernel,
  output logic          err_ovf,
  output logic          err_resid
);
  localparam int NW = $clog2(N) > 0 ? $clog2(N) : 1;
  localparam int JW = $clog2(M);
  localparam logic signed [AW-1:0] XMAX = AW'((64'sd1 <<< (XW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] XMIN = ~XMAX;
  typedef enum logic [1:0] {IDLE, RUN, TAIL, FIN} state_t;
  state_t r_state, w_next;
  logic signed [HW-1:0] r_h [1:M-1];
  logic signed [XW-1:0] r_hist [1:M-1];
  logic [NW-1:0] r_n;
  logic [JW-1:0] r_j;
  logic signed [AW-1:0] w_acc;
  logic signed [HW+XW-1:0] w_prod;
  logic signed [XW-1:0] w_sat;
  logic w_clip, w_y_acc, w_h0_ok;
  assign w_h0_ok = h_flat[HW-1:0] == HW'(1);
  assign y_ready = r_state == RUN ? (!x_valid || x_ready) : r_state == TAIL;
  assign w_y_acc = y_valid && y_ready;
  assign busy    = r_state != IDLE;
  assign done    = r_state == FIN && !x_valid;
  assign w_clip  = w_acc > XMAX || w_acc < XMIN;
  assign w_sat   = w_acc > XMAX ? XMAX[XW-1:0] : w_acc < XMIN ? XMIN[XW-1:0] : w_acc[XW-1:0];
  // y minus the kernel tail applied to recent x; in TAIL history holds zeros past x[N-1], so zero acc means the tail matched
  always_comb begin
    w_acc  = AW'($signed(y_data));
    w_prod = '0;
    for (int k = 1; k < M; k++) begin
      w_prod = r_h[k] * r_hist[k];
      w_acc  = w_acc - AW'(w_prod);
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // frame sequencing; FIN holds until the output register has drained
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? (w_h0_ok ? RUN : FIN) : IDLE;
      RUN:     w_next = (w_y_acc && r_n == NW'(N - 1)) ? TAIL : RUN;
      TAIL:    w_next = (w_y_acc && r_j == JW'(M - 2)) ? FIN : TAIL;
      default: w_next = x_valid ? FIN : IDLE;
    endcase
  end
  // kernel latch, x history, sample counters and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k < M; k++) r_h[k] <= '0;
      for (int k = 1; k < M; k++) r_hist[k] <= '0;
      r_n        <= '0;
      r_j        <= '0;
      err_kernel <= 1'b0;
      err_ovf    <= 1'b0;
      err_resid  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      for (int k = 1; k < M; k++) r_h[k] <= h_flat[k*HW +: HW];
      for (int k = 1; k < M; k++) r_hist[k] <= '0;
      r_n        <= '0;
      r_j        <= '0;
      err_kernel <= !w_h0_ok;
      err_ovf    <= 1'b0;
      err_resid  <= 1'b0;
    end else if (w_y_acc) begin
      r_hist[1] <= r_state == RUN ? w_sat : '0;
      for (int k = 2; k < M; k++) r_hist[k] <= r_hist[k-1];
      if (r_state == RUN) begin
        r_n     <= r_n + 1'b1;
        err_ovf <= err_ovf | w_clip;
      end else begin
        r_j       <= r_j + 1'b1;
        err_resid <= err_resid | (w_acc != '0);
      end
    end
  end
  // single output register: a new x can replace the retiring one in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      x_valid <= 1'b0;
      x_last  <= 1'b0;
      x_data  <= '0;
    end else if (w_y_acc && r_state == RUN) begin
      x_valid <= 1'b1;
      x_last  <= r_n == NW'(N - 1);
      x_data  <= w_sat;
    end else if (x_ready) begin
      x_valid <= 1'b0;
      x_last  <= 1'b0;
    end
  end
endmodule
